wallace_mul_pipe: RTL and testbench

WALLACE_MUL_PIPE -- requirements
Module: wallace_mul_pipe

---
 rtl/mul_pkg.sv | 52 +++++
 rtl/mul_csa.sv | 26 ++
 rtl/wallace_mul_pipe.sv | 177 +++++++++++++++++
 tb/tb_wallace_mul_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and elaboration helpers for wallace_mul_pipe.
//   mul_op_e  : operation encoding carried with each operand through the pipe
//   mul_sc_t  : sum/carry pair plus op, held between the CSA tree and the
//               final adder when the two-stage build is selected
//   csa_rows / csa_levels : row counts of the Wallace reduction, used by the
//               generate loops that build the tree
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    // Largest supported operand width; sizes the pipeline struct.
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic [2*MAX_WIDTH-1:0] sum;
        logic [2*MAX_WIDTH-1:0] carry;
        mul_op_e                op;
    } mul_sc_t;

    // One Wallace level turns every full group of three rows into two and
    // passes the remaining zero, one or two rows through untouched.
    function automatic int csa_rows_next(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int csa_rows(input int n_pp, input int lvl);
        int n;
        n = n_pp;
        for (int i = 0; i < lvl; i++) begin
            n = csa_rows_next(n);
        end
        return n;
    endfunction

    function automatic int csa_levels(input int n_pp);
        int n;
        int l;
        n = n_pp;
        l = 0;
        while (n > 2) begin
            n = csa_rows_next(n);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/mul_csa.sv
// mul_csa: WIDTH-bit 3:2 carry-save compressor (one tree cell).
//   a, b, c : three rows of equal weight
//   sum     : bitwise sum row
//   carry   : carry row, already shifted one place left so it aligns with
//             sum; the carry out of the top bit falls outside the product
//             and is dropped
module mul_csa
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum = a ^ b ^ c;

    assign carry[WIDTH-1:1] = (a[WIDTH-2:0] & b[WIDTH-2:0])
                            | (a[WIDTH-2:0] & c[WIDTH-2:0])
                            | (b[WIDTH-2:0] & c[WIDTH-2:0]);
    assign carry[0] = 1'b0;

endmodule

// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe: pipelined WIDTH x WIDTH multiplier with valid/ready
// handshake, computing MUL / MULH / MULHSU / MULHU through a Wallace tree of
// mul_csa cells followed by one carry-propagate add.
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      drops every in-flight operation; blocks acceptance that cycle
//   in_valid_i   operand valid        in_ready_o  operand can be accepted
//   op_i         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a_i, b_i     operands (rs1, rs2)
//   out_valid_o  result valid         out_ready_i consumer ready
//   result_o     selected product half
// Build option WALLACE_MUL_PIPE2_EN: when defined, the carry-save pair is
// registered before the final adder (accept-to-valid latency 2); otherwise
// tree and adder share one cycle in front of the output register (latency 1).
module wallace_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int PW   = 2 * WIDTH;
    localparam int NPP  = WIDTH + 2;
    localparam int NLVL = csa_levels(NPP);

    function automatic logic [WIDTH-1:0] sel_half(input logic [PW-1:0] prod,
                                                  input mul_op_e       op);
        return (op == MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
    endfunction

    // ---- stage p0: operand conditioning, partial products, CSA tree ----
    mul_op_e              op_p0;
    logic                 a_signed_p0;
    logic                 b_neg_p0;
    logic signed [PW-1:0] a_ext_p0;
    logic [PW-1:0]        pp_p0 [NPP];
    logic [PW-1:0]        sum_p0;
    logic [PW-1:0]        carry_p0;
    logic                 accept_p0;

    assign op_p0       = mul_op_e'(op_i);
    assign a_signed_p0 = (op_p0 != MULHU);
    // A signed b contributes -2^WIDTH * b[msb] on top of its unsigned bits.
    assign b_neg_p0    = ((op_p0 == MUL) || (op_p0 == MULH)) && b_i[WIDTH-1];
    assign a_ext_p0    = a_signed_p0 ? {{WIDTH{a_i[WIDTH-1]}}, a_i}
                                     : {{WIDTH{1'b0}}, a_i};

    // Rows 0..WIDTH-1 are the unsigned bits of b. The negative weight of a
    // signed b is -(a << WIDTH) = ~(a << WIDTH) + 1, split into an inverted
    // row and a lone +1 row so the tree absorbs it without a separate adder.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp_p0[i] = b_i[i] ? PW'(a_ext_p0 << i) : '0;
        end
        pp_p0[WIDTH]   = b_neg_p0 ? ~PW'(a_ext_p0 << WIDTH) : '0;
        pp_p0[WIDTH+1] = {{(PW-1){1'b0}}, b_neg_p0};
    end

    for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
        localparam int NOUT = csa_rows(NPP, l);
        logic [PW-1:0] rows [NOUT];

        if (l == 0) begin : g_pp
            for (genvar k = 0; k < NPP; k++) begin : g_row
                assign rows[k] = pp_p0[k];
            end
        end else begin : g_red
            localparam int NIN   = csa_rows(NPP, l - 1);
            localparam int NCELL = NIN / 3;

            for (genvar j = 0; j < NCELL; j++) begin : g_cell
                mul_csa #(.WIDTH(PW)) u_csa (
                    .a     (g_lvl[l-1].rows[3*j]),
                    .b     (g_lvl[l-1].rows[3*j+1]),
                    .c     (g_lvl[l-1].rows[3*j+2]),
                    .sum   (rows[2*j]),
                    .carry (rows[2*j+1])
                );
            end

            // Leftover rows land directly after the compressed pairs.
            for (genvar k = 3 * NCELL; k < NIN; k++) begin : g_pass
                assign rows[k - NCELL] = g_lvl[l-1].rows[k];
            end
        end
    end

    assign sum_p0   = g_lvl[NLVL].rows[0];
    assign carry_p0 = g_lvl[NLVL].rows[1];

    logic             vld_p2;
    logic             ready_p2;
    logic [WIDTH-1:0] result_p2;

    assign ready_p2 = !vld_p2 || out_ready_i;

`ifdef WALLACE_MUL_PIPE2_EN
    logic          vld_p1;
    logic          ready_p1;
    mul_sc_t       sc_p1;
    logic [PW-1:0] prod_p1;

    assign ready_p1   = !vld_p1 || ready_p2;
    assign in_ready_o = ready_p1;
    assign accept_p0  = in_valid_i && ready_p1 && !flush_i;

    // ---- stage p1: registered carry-save pair, final adder ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
            sc_p1  <= '0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (ready_p1) begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                sc_p1.sum   <= (2*MAX_WIDTH)'(sum_p0);
                sc_p1.carry <= (2*MAX_WIDTH)'(carry_p0);
                sc_p1.op    <= op_p0;
            end
        end
    end

    assign prod_p1 = sc_p1.sum[PW-1:0] + sc_p1.carry[PW-1:0];

    // ---- stage p2: output register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
        end else if (flush_i) begin
            vld_p2 <= 1'b0;
        end else if (ready_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result_p2 <= sel_half(prod_p1, sc_p1.op);
            end
        end
    end
`else
    logic [PW-1:0] prod_p0;

    assign in_ready_o = ready_p2;
    assign accept_p0  = in_valid_i && ready_p2 && !flush_i;
    assign prod_p0    = sum_p0 + carry_p0;

    // ---- stage p2: output register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
        end else if (flush_i) begin
            vld_p2 <= 1'b0;
        end else if (ready_p2) begin
            vld_p2 <= accept_p0;
            if (accept_p0) begin
                result_p2 <= sel_half(prod_p0, op_p0);
            end
        end
    end
`endif

    assign out_valid_o = vld_p2;
    assign result_o    = result_p2;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// tb_wallace_mul_pipe: directed and randomised bench for wallace_mul_pipe,
// with a WIDTH=32 instance for the main scenarios and a WIDTH=8 instance for
// the narrow edge values. Honours WALLACE_MUL_PIPE2_EN for expected latency.
module tb_wallace_mul_pipe;

`ifdef WALLACE_MUL_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;

    logic        flush8 = 1'b0;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  result8;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] got_q [$];
    int          rd_ptr = 0;

    wallace_mul_pipe #(.WIDTH(32)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o)
    );

    wallace_mul_pipe #(.WIDTH(8)) u_dut8 (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush8),
        .in_valid_i  (in_valid8),
        .in_ready_o  (in_ready8),
        .op_i        (op8),
        .a_i         (a8),
        .b_i         (b8),
        .out_valid_o (out_valid8),
        .out_ready_i (out_ready8),
        .result_o    (result8)
    );

    initial forever #5 clk = ~clk;

    // Output transfers are taken at the negedge before the edge that
    // completes them; stimulus only changes just after a rising edge.
    initial forever begin
        @(negedge clk);
        if (rst_ni && out_valid_o && out_ready_i) got_q.push_back(result_o);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] ae, be, p;
        ae = (op == 2'b11) ? $signed({32'd0, a}) : $signed({{32{a[31]}}, a});
        be = (op[1] == 1'b0) ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
        p  = ae * be;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand and returns just after the edge that accepts it,
    // leaving in_valid_i high so callers can chain operands with no bubble.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc = 1'b0;
        in_valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready_o && !flush_i;
            step();
        end
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready_o=%0b, required 1 within 200 cycles", in_ready_o);
        end
    endtask

    task automatic idle();
        in_valid_i = 1'b0; op_i = 2'b10; a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678;
    endtask

    task automatic wait_result(output logic [31:0] r, output bit ok);
        ok = 1'b0; r = '0;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (got_q.size() > rd_ptr) begin
                r = got_q[rd_ptr]; rd_ptr++; ok = 1'b1;
            end else begin
                step();
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b, want 0", out_valid_o); end
        n_vec++; if (result_o !== 32'd0) begin n_err++; $display("FAIL rst_result: got 0x%08h, want 0", result_o); end
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b, want 1", in_ready_o); end
        n_vec++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid8: got %0b, want 0", out_valid8); end
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %0b, want 1", in_ready_o); end
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid: got %0b, want 0", out_valid_o); end
    endtask

    task automatic test_edge_values();
        logic [1:0]  ops [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2};
        logic [31:0] av  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] bv  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        logic [31:0] ex  [8] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                 32'h40000000, 32'h40000000, 32'h00000000, 32'h3FFFFFFF};
        logic [31:0] r;
        bit          ok;
        time         t0;
        out_ready_i = 1'b1;
        t0 = $time;
        for (int i = 0; i < 8; i++) issue(ops[i], av[i], bv[i]);
        n_vec++;
        if (($time - t0) != 80) begin
            n_err++; $display("FAIL throughput: 8 ops took %0t time units, want 80", $time - t0);
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            wait_result(r, ok);
            n_vec++;
            if (!ok || r !== ex[i]) begin
                n_err++; $display("FAIL edge[%0d]: got 0x%08h (ok=%0b), want 0x%08h", i, r, ok, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex [3] = '{32'd6, 32'd20, 32'd42};
        logic [31:0] r;
        bit          ok;
        out_ready_i = 1'b0;
        fork
            begin
                issue(2'd0, 32'd2, 32'd3);
                issue(2'd0, 32'd4, 32'd5);
                issue(2'd0, 32'd6, 32'd7);
                idle();
            end
            begin
                repeat (3) step();
                n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready: got %0b, want 0", in_ready_o); end
                n_vec++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_stall_valid: got %0b, want 1", out_valid_o); end
                n_vec++; if (result_o !== 32'd6) begin n_err++; $display("FAIL b2b_stall_hold: got 0x%08h, want 0x6", result_o); end
                out_ready_i = 1'b1;
            end
        join
        for (int i = 0; i < 3; i++) begin
            wait_result(r, ok);
            n_vec++;
            if (!ok || r !== ex[i]) begin
                n_err++; $display("FAIL b2b[%0d]: got %0d (ok=%0b), want %0d", i, r, ok, ex[i]);
            end
        end
        repeat (5) step();
        n_vec++;
        if (got_q.size() != rd_ptr) begin
            n_err++; $display("FAIL b2b_extra: %0d extra results, want 0", got_q.size() - rd_ptr);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        bit          ok;
        int          k;
        out_ready_i = 1'b0;
        issue(2'd0, 32'h10, 32'h10);
        a_i = 32'd5; b_i = 32'd5; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        idle();
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b, want 0", out_valid_o); end
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %0b, want 1", in_ready_o); end
        out_ready_i = 1'b1;
        repeat (4) step();
        n_vec++;
        if (got_q.size() != rd_ptr) begin
            n_err++; $display("FAIL flush_leak: %0d results after flush, want 0", got_q.size() - rd_ptr);
            rd_ptr = got_q.size();
        end
        issue(2'd0, 32'd3, 32'd3);
        idle();
        k = 0;
        while (!out_valid_o && k < 10) begin step(); k++; end
        n_vec++;
        if (k != LAT - 1) begin n_err++; $display("FAIL flush_latency: extra cycles %0d, want %0d", k, LAT - 1); end
        wait_result(r, ok);
        n_vec++;
        if (!ok || r !== 32'd9) begin n_err++; $display("FAIL flush_next: got %0d (ok=%0b), want 9", r, ok); end
    endtask

    task automatic test_reset_midflight();
        out_ready_i = 1'b0;
        issue(2'd0, 32'd7, 32'd7);
        idle();
        #2;
        rst_ni = 1'b0;
        #1;
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b, want 0", out_valid_o); end
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %0b, want 1", in_ready_o); end
        n_vec++; if (result_o !== 32'd0) begin n_err++; $display("FAIL midrst_result: got 0x%08h, want 0", result_o); end
        #4;
        rst_ni = 1'b1;
        step();
        out_ready_i = 1'b1;
        repeat (5) step();
        n_vec++;
        if (got_q.size() != rd_ptr) begin
            n_err++; $display("FAIL midrst_stale: %0d results after reset, want 0", got_q.size() - rd_ptr);
            rd_ptr = got_q.size();
        end
    endtask

    task automatic test_random();
        logic [31:0] edge_v [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] exp_q [$];
        logic [31:0] r, a, b;
        logic [1:0]  op;
        bit          ok;
        bit          done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    op = 2'($urandom_range(0, 3));
                    a  = $urandom;
                    b  = $urandom;
                    if ($urandom_range(0, 7) == 0) a = edge_v[$urandom_range(0, 4)];
                    if ($urandom_range(0, 7) == 0) b = edge_v[$urandom_range(0, 4)];
                    issue(op, a, b);
                    exp_q.push_back(ref_mul(op, a, b));
                    if ($urandom_range(0, 7) == 0) begin idle(); step(); end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready_i = ($urandom_range(0, 3) != 0);
                    step();
                end
                out_ready_i = 1'b1;
            end
        join
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_result(r, ok);
            n_vec++;
            if (!ok || r !== exp_q[i]) begin
                n_err++; $display("FAIL random[%0d]: got 0x%08h (ok=%0b), want 0x%08h", i, r, ok, exp_q[i]);
            end
        end
    endtask

    task automatic test_width8();
        logic [1:0] ops [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2};
        logic [7:0] av  [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h7F};
        logic [7:0] bv  [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80};
        logic [7:0] ex  [8] = '{8'h01, 8'h00, 8'hFF, 8'hFE, 8'h40, 8'h40, 8'h00, 8'h3F};
        logic [7:0] r;
        bit         acc, got;
        out_ready8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid8 = 1'b1; op8 = ops[i]; a8 = av[i]; b8 = bv[i];
            acc = 1'b0;
            for (int n = 0; n < 50 && !acc; n++) begin
                @(negedge clk);
                acc = in_ready8;
                step();
            end
            in_valid8 = 1'b0;
            got = 1'b0; r = '0;
            for (int n = 0; n < 50 && !got; n++) begin
                @(negedge clk);
                if (out_valid8) begin r = result8; got = 1'b1; end
                step();
            end
            n_vec++;
            if (!acc || !got || r !== ex[i]) begin
                n_err++; $display("FAIL w8[%0d]: got 0x%02h (acc=%0b got=%0b), want 0x%02h", i, r, acc, got, ex[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_values();
        test_back_to_back();
        test_flush();
        test_reset_midflight();
        test_random();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
